// File: rtl/multicycle_add.sv
// multicycle_add: adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per cycle
module multicycle_add #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CHUNK:0] slice;
  logic msb_cin, last;
  int idx;
  always_comb begin
    idx = int'(cnt_q) * CHUNK;
    slice = {1'b0, a_q[idx +: CHUNK]} + {1'b0, b_q[idx +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
    // on the final slice, a^b^s at the top bit recovers the carry into the MSB
    msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice[CHUNK-1];
    last = cnt_q == CW'(N - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    if (state_q == RUN) begin
      acc_d[idx +: CHUNK] = slice[CHUNK-1:0];
      carry_d = slice[CHUNK];
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        sum_d = acc_d;
        cout_d = slice[CHUNK];
        ovf_d = msb_cin ^ slice[CHUNK];
        zero_d = acc_d == '0;
      end
    end else if (start) begin
      state_d = RUN;
      a_d = a;
      b_d = sub ? ~b : b;
      carry_d = sub | cin;
      cnt_d = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_multicycle_add.sv
// tb_multicycle_add: vector table, corner sequences and random ops against an arithmetic model
module tb_multicycle_add;
  logic clk = 0, reset = 1, start = 0, cin = 0, sub = 0;
  logic [31:0] a = 0, b = 0;
  logic busy8, done8, cout8, ovf8, zero8;
  logic busy32, done32, cout32, ovf32, zero32;
  logic busy1, done1, cout1, ovf1, zero1;
  logic [31:0] sum8, sum32, sum1;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  multicycle_add #(.WIDTH(32), .CHUNK(8)) dut8 (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8));
  multicycle_add #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32));
  multicycle_add #(.WIDTH(32), .CHUNK(1)) dut1 (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1));
  typedef struct {
    logic [31:0] a, b;
    logic cin, sub;
    logic [31:0] sum;
    logic cout, ovf, zero;
  } vec_t;
  vec_t tbl[8];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // {cout, ovf, zero, sum} from plain integer arithmetic
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    longint sv;
    logic [31:0] r;
    logic co;
    sv = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    r = s ? x - y : x + y + 32'(ci);
    co = s ? x >= y : (64'(x) + 64'(y) + 64'(ci)) > 64'hFFFFFFFF;
    return {co, sv > 64'sd2147483647 || sv < -64'sd2147483648, r == 0, r};
  endfunction
  task automatic check_res(input string tag, input logic [34:0] exp);
    check({tag, " sum"}, 64'(sum8), 64'(exp[31:0]));
    check({tag, " cout"}, 64'(cout8), 64'(exp[34]));
    check({tag, " ovf"}, 64'(ovf8), 64'(exp[33]));
    check({tag, " zero"}, 64'(zero8), 64'(exp[32]));
  endtask
  task automatic wait_done(input int l0, output int lat, output int bc);
    lat = l0;
    bc = 0;
    while (!done8 && lat < 100) begin
      bc += int'(busy8);
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts,
                        output int lat, output int bc);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(0, lat, bc);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat, bc, seen, l8, l32, l1;
    tbl[0] = '{32'h5, 32'h3, 0, 0, 32'h8, 0, 0, 0};
    tbl[1] = '{32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1};
    tbl[2] = '{32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 1, 0};
    tbl[3] = '{32'h5, 32'h5, 1, 1, 32'h0, 1, 0, 1};
    tbl[4] = '{32'h3, 32'h5, 0, 1, 32'hFFFFFFFE, 0, 0, 0};
    tbl[5] = '{32'h0, 32'h0, 1, 0, 32'h1, 0, 0, 0};
    tbl[6] = '{32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0, 0};
    tbl[7] = '{32'h80000000, 32'h1, 0, 1, 32'h7FFFFFFF, 1, 1, 0};
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy8), 0);
    check("reset done", 64'(done8), 0);
    check("reset sum", 64'(sum8), 0);
    check("reset flags", 64'({cout8, ovf8, zero8}), 0);
    a = 1; b = 1; start = 1;
    @(negedge clk);
    check("start during reset", 64'(busy8), 0);
    start = 0; reset = 0;
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat, bc);
      check($sformatf("vec%0d latency", i), 64'(lat), 4);
      check($sformatf("vec%0d busy cycles", i), 64'(bc), 4);
      check_res($sformatf("vec%0d", i), {tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].sum});
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), 64'(done8), 0);
    end
    repeat (3) @(negedge clk);
    check("result hold", 64'(sum8), 64'h7FFFFFFF);
    a = 1; b = 2; cin = 0; sub = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("sum held during run", 64'(sum8), 64'h7FFFFFFF);
    reset = 1;
    #1;
    check("mid-run reset busy", 64'(busy8), 0);
    check("mid-run reset sum", 64'(sum8), 0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen += int'(done8);
    end
    check("no done after abort", 64'(seen), 0);
    run_op(32'h1, 32'h2, 0, 0, lat, bc);
    check("post-reset latency", 64'(lat), 4);
    check_res("post-reset", model(32'h1, 32'h2, 0, 0));
    @(negedge clk);
    a = 10; b = 20; cin = 0; sub = 0; start = 1;
    @(negedge clk);
    a = 99; b = 1; cin = 1; sub = 1;
    @(negedge clk);
    start = 0;
    wait_done(1, lat, bc);
    check("ignored start latency", 64'(lat), 4);
    check_res("ignored start", model(32'd10, 32'd20, 0, 0));
    a = 7; b = 8; cin = 0; sub = 1; start = 1;
    @(negedge clk);
    start = 0;
    check("back-to-back busy", 64'(busy8), 1);
    wait_done(0, lat, bc);
    check("back-to-back latency", 64'(lat), 4);
    check_res("back-to-back", model(32'd7, 32'd8, 0, 1));
    repeat (40) begin
      logic [31:0] ra, rb;
      logic rc, rs;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rc, rs, lat, bc);
      check("rand latency", 64'(lat), 4);
      check_res($sformatf("rand %h %s %h c%0d", ra, rs ? "-" : "+", rb, rc), model(ra, rb, rc, rs));
    end
    repeat (40) @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; cin = 0; sub = 0; start = 1;
    @(negedge clk);
    start = 0;
    l8 = -1; l32 = -1; l1 = -1;
    for (int k = 0; k < 40; k++) begin
      if (done8 && l8 < 0) l8 = k;
      if (done32 && l32 < 0) l32 = k;
      if (done1 && l1 < 0) l1 = k;
      @(negedge clk);
    end
    check("chunk8 latency", 64'(l8), 4);
    check("chunk32 latency", 64'(l32), 1);
    check("chunk1 latency", 64'(l1), 32);
    check("chunk32 sum", 64'(sum32), 64'h23456789);
    check("chunk1 sum", 64'(sum1), 64'h23456789);
    check("chunk32 flags", 64'({cout32, ovf32, zero32}), 0);
    check("chunk1 flags", 64'({cout1, ovf1, zero1}), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multicycle_add.md
MULTICYCLE_ADD -- requirements
Module: multicycle_add

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per cycle. WIDTH SHALL be an integer multiple of CHUNK, and 1 <= CHUNK <= WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 SHALL have port sub, input, 1 bit: 0 selects A+B+cin; 1 selects A-B.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 SHALL have port sum, output, WIDTH bits: registered result.
REQ-013 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-014 SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-015 SHALL have port zero, output, 1 bit: high when sum equals 0.

Function
REQ-016 SHALL implement three states, IDLE, RUN and DONE, with N = WIDTH/CHUNK.
REQ-017 SHALL, in IDLE or DONE with start=1 at a rising edge, latch a, b, cin and sub, clear the chunk counter and enter RUN.
REQ-018 SHALL ignore start while in RUN; latched operands SHALL be unaffected.
REQ-019 SHALL, in RUN, add one CHUNK-bit slice per cycle, LSB slice first, propagating carry between slices in a carry register.
REQ-020 SHALL, for sub=1, use operand ~B with an initial carry of 1 and ignore cin.
REQ-021 SHALL, for sub=0, use operand B with an initial carry of cin.
REQ-022 SHALL, after the N-th slice, enter DONE and update sum, cout, ovf and zero in the same edge.
REQ-023 SHALL assert done only in DONE, for exactly one cycle; DONE SHALL return to IDLE unless start=1.
REQ-024 SHALL assert done exactly N cycles after the edge that accepted start; CHUNK=WIDTH gives latency 1.
REQ-025 SHALL assert busy exactly while in RUN.
REQ-026 SHALL hold sum, cout, ovf and zero at the previous result during RUN, changing them only at completion.
REQ-027 SHALL hold the result after completion until the next completion or reset.
REQ-028 SHALL compute cout as the carry out of bit WIDTH-1; for sub=1, cout=1 means no borrow (A >= B unsigned).
REQ-029 SHALL compute ovf as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-030 SHALL compute zero from the final sum value.
REQ-031 SHALL, on start=1 in the DONE cycle, pulse done normally and enter RUN with the new operands (back-to-back operation).

Reset
REQ-032 SHALL, on reset=1 at any time including mid-RUN, immediately force the IDLE state, busy=0, done=0, sum=0, cout=0, ovf=0 and zero=0; any operation in progress SHALL be abandoned with no done pulse.
REQ-033 SHALL ignore start while reset=1; the first start SHALL be accepted on the first rising edge after reset deasserts.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-034 SHALL verify: a=5, b=3, cin=0, sub=0 -> done exactly 4 cycles after start, sum=8, cout=0, ovf=0, zero=0, busy high for 4 cycles.
REQ-035 SHALL verify: a=0xFFFFFFFF, b=1, sub=0 -> sum=0, cout=1, ovf=0, zero=1; and a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-036 SHALL verify subtraction: a=5, b=5, sub=1, cin=1 -> sum=0, cout=1, zero=1; and a=3, b=5, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-037 SHALL verify reset mid-operation: reset asserted 2 cycles into RUN -> busy=0, sum=0 immediately and no done pulse; a new start afterwards completes normally.
REQ-038 SHALL verify start during RUN with different operands is ignored, the original result is returned, and a start in the DONE cycle yields a second done exactly 4 cycles later.
REQ-039 SHALL verify CHUNK=32 (latency 1) and CHUNK=1 (latency 32) with a=0x12345678, b=0x11111111 -> sum=0x23456789.
